// File: rtl/textlcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : textlcd_pkg
//  Description : Shared state encodings and HD44780-style command bytes for
//                the text LCD refresh engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package textlcd_pkg;

    // Controller sequence: power-up wait, init commands, redraw, idle
    typedef enum logic [2:0] {
        PWR_DLY   = 3'd0,
        FUNC_SET  = 3'd1,
        DISP_ON   = 3'd2,
        CLEAR     = 3'd3,
        ENTRY     = 3'd4,
        LINE_ADDR = 3'd5,
        WR_CHAR   = 3'd6,
        IDLE      = 3'd7
    } lcd_state_t;

    // Phases of a single byte transfer on the LCD bus
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_STROBE = 2'd2,
        PH_WAIT   = 2'd3
    } xfer_phase_t;

    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_FUNC_8B1L = 8'h30;  // 8-bit bus, 1 line, 5x8 font
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display (slow command)
    localparam logic [7:0] CMD_ENTRY     = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_DDRAM_L0  = 8'h80;  // DDRAM address of line 0
    localparam logic [7:0] CMD_DDRAM_L1  = 8'hC0;  // DDRAM address of line 1

endpackage
`default_nettype wire

// File: rtl/textlcd_refresh_if.sv
`default_nettype none
// ============================================================================
//  Module      : textlcd_refresh_if
//  Description : Host-side redraw handshake, character fetch port and LCD
//                bus of the text LCD refresh engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface textlcd_refresh_if #(
    parameter int ADDR_W = 5
);
    logic              refresh;
    logic [7:0]        char_data;
    logic [ADDR_W-1:0] char_addr;
    logic              busy;
    logic              done;
    logic              lcd_e;
    logic              lcd_rs;
    logic              lcd_rw;
    logic [7:0]        lcd_data;

    // Controller side
    modport master (
        input  refresh, char_data,
        output char_addr, busy, done, lcd_e, lcd_rs, lcd_rw, lcd_data
    );

    // Host / display side
    modport slave (
        output refresh, char_data,
        input  char_addr, busy, done, lcd_e, lcd_rs, lcd_rw, lcd_data
    );
endinterface
`default_nettype wire

// File: rtl/lcd_byte_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_byte_xfer
//  Description : One LCD byte write: setup cycle, E strobe, then a settle
//                wait (long after Clear). ready rises in the last wait cycle
//                so back-to-back bytes need no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_byte_xfer
    import textlcd_pkg::*;
#(
    parameter int E_PULSE    = 2,
    parameter int CMD_WAIT   = 30,
    parameter int CLEAR_WAIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       ready,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);
    localparam logic [15:0] c_E_LAST   = 16'(E_PULSE - 1);
    localparam logic [15:0] c_CMD_LAST = 16'(CMD_WAIT - 1);
    localparam logic [15:0] c_CLR_LAST = 16'(CLEAR_WAIT - 1);

    xfer_phase_t r_phase, w_phase_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_e, r_rs, r_long;
    logic [7:0]  r_data;
    logic [15:0] w_wait_last;
    logic        w_wait_end;

    assign w_wait_last = r_long ? c_CLR_LAST : c_CMD_LAST;
    assign w_wait_end  = (r_phase == PH_WAIT) && (r_cnt == w_wait_last);
    assign ready       = (r_phase == PH_IDLE) || w_wait_end;
    assign lcd_e       = r_e;
    assign lcd_rs      = r_rs;
    assign lcd_data    = r_data;

    // Phase register; E is registered so the strobe is glitch-free and
    // drops immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_e     <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_e     <= (w_phase_nxt == PH_STROBE);
        end
    end

    // Next phase and cycle counter
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        case (r_phase)
            PH_IDLE: begin
                if (start) begin
                    w_phase_nxt = PH_SETUP;
                    w_cnt_nxt   = '0;
                end
            end
            PH_SETUP: begin
                w_phase_nxt = PH_STROBE;
                w_cnt_nxt   = '0;
            end
            PH_STROBE: begin
                if (r_cnt == c_E_LAST) begin
                    w_phase_nxt = PH_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            PH_WAIT: begin
                if (w_wait_end) begin
                    w_phase_nxt = start ? PH_SETUP : PH_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: w_phase_nxt = PH_IDLE;
        endcase
    end

    // Byte latch: RS/data held from the setup cycle until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs   <= 1'b0;
            r_data <= 8'h00;
            r_long <= 1'b0;
        end else if (start && ready) begin
            r_rs   <= rs;
            r_data <= data;
            r_long <= long_wait;
        end
    end

endmodule
`default_nettype wire

// File: rtl/textlcd_refresh.sv
`default_nettype none
// ============================================================================
//  Module      : textlcd_refresh
//  Description : Initialises a character LCD after power-up, then redraws
//                the whole screen from a character source on every refresh
//                request (one-deep pending request while busy).
//  Revision    : 1.0 - initial release
// ============================================================================
module textlcd_refresh
    import textlcd_pkg::*;
#(
    parameter int INIT_DELAY = 70,
    parameter int CMD_WAIT   = 30,
    parameter int CLEAR_WAIT = 100,
    parameter int E_PULSE    = 2,
    parameter int NUM_LINES  = 2,
    parameter int LINE_CHARS = 16
) (
    input  logic               clk,
    input  logic               rst,
    textlcd_refresh_if.master  bus
);
    localparam int c_TOTAL  = NUM_LINES * LINE_CHARS;
    localparam int c_ADDR_W = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    localparam int c_COL_W  = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;

    localparam logic [15:0]        c_DLY_LAST  = 16'(INIT_DELAY - 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL  = c_COL_W'(LINE_CHARS - 1);
    localparam logic               c_LAST_LINE = 1'(NUM_LINES - 1);

    lcd_state_t          r_state, w_state_nxt;
    logic [15:0]         r_dly;
    logic                r_line;
    logic [c_COL_W-1:0]  r_col;
    logic [c_ADDR_W-1:0] r_addr;
    logic                r_last_sent;
    logic                r_pending;
    logic                r_busy;
    logic                r_done;

    logic                w_start, w_rs, w_long, w_ready, w_finish, w_req;
    logic [7:0]          w_byte;

    assign w_req         = r_pending | bus.refresh;
    assign bus.char_addr = r_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.lcd_rw    = 1'b0;

    lcd_byte_xfer #(
        .E_PULSE    (E_PULSE),
        .CMD_WAIT   (CMD_WAIT),
        .CLEAR_WAIT (CLEAR_WAIT)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .rs        (w_rs),
        .data      (w_byte),
        .long_wait (w_long),
        .ready     (w_ready),
        .lcd_e     (bus.lcd_e),
        .lcd_rs    (bus.lcd_rs),
        .lcd_data  (bus.lcd_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PWR_DLY;
        else     r_state <= w_state_nxt;
    end

    // Next state and byte to issue; each byte state advances once the
    // transfer engine accepts its byte
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rs        = 1'b0;
        w_long      = 1'b0;
        w_byte      = 8'h00;
        w_finish    = 1'b0;
        case (r_state)
            PWR_DLY: begin
                if (r_dly == c_DLY_LAST) w_state_nxt = FUNC_SET;
            end
            FUNC_SET: begin
                w_byte  = (NUM_LINES == 2) ? CMD_FUNC_8B2L : CMD_FUNC_8B1L;
                w_start = w_ready;
                if (w_ready) w_state_nxt = DISP_ON;
            end
            DISP_ON: begin
                w_byte  = CMD_DISP_ON;
                w_start = w_ready;
                if (w_ready) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                w_byte  = CMD_CLEAR;
                w_long  = 1'b1;
                w_start = w_ready;
                if (w_ready) w_state_nxt = ENTRY;
            end
            ENTRY: begin
                w_byte  = CMD_ENTRY;
                w_start = w_ready;
                if (w_ready) w_state_nxt = LINE_ADDR;
            end
            LINE_ADDR: begin
                w_byte  = r_line ? CMD_DDRAM_L1 : CMD_DDRAM_L0;
                w_start = w_ready;
                if (w_ready) w_state_nxt = WR_CHAR;
            end
            WR_CHAR: begin
                if (r_last_sent) begin
                    // Last character has finished its wait: redraw complete
                    if (w_ready) begin
                        w_finish    = 1'b1;
                        w_state_nxt = w_req ? LINE_ADDR : IDLE;
                    end
                end else begin
                    w_rs    = 1'b1;
                    w_byte  = bus.char_data;
                    w_start = w_ready;
                    if (w_ready && (r_col == c_LAST_COL) && (r_line != c_LAST_LINE))
                        w_state_nxt = LINE_ADDR;
                end
            end
            IDLE: begin
                if (bus.refresh) w_state_nxt = LINE_ADDR;
            end
            default: w_state_nxt = PWR_DLY;
        endcase
    end

    // Delay/line/column counters, pending request, busy and done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dly       <= '0;
            r_line      <= 1'b0;
            r_col       <= '0;
            r_addr      <= '0;
            r_last_sent <= 1'b0;
            r_pending   <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_dly  <= (r_state == PWR_DLY) ? r_dly + 16'd1 : 16'd0;
            r_done <= w_finish;
            r_busy <= (w_state_nxt != IDLE);

            if (w_finish)                              r_pending <= 1'b0;
            else if (bus.refresh && (r_state != IDLE)) r_pending <= 1'b1;

            if (w_finish) begin
                r_line      <= 1'b0;
                r_col       <= '0;
                r_addr      <= '0;
                r_last_sent <= 1'b0;
            end else if ((r_state == WR_CHAR) && w_start) begin
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                    if (r_line == c_LAST_LINE) begin
                        // Address parks on the final index until completion
                        r_last_sent <= 1'b1;
                    end else begin
                        r_line <= r_line + 1'b1;
                        r_addr <= r_addr + 1'b1;
                    end
                end else begin
                    r_col  <= r_col + 1'b1;
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_textlcd_refresh.sv
`default_nettype none
// ============================================================================
//  Module      : tb_textlcd_refresh
//  Description : Directed self-checking bench for textlcd_refresh: a 2x4
//                display instance and a 1x4 display instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_textlcd_refresh;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    textlcd_refresh_if #(.ADDR_W(3)) bus  ();
    textlcd_refresh_if #(.ADDR_W(2)) bus2 ();

    assign bus.char_data  = 8'h41 + 8'(bus.char_addr);
    assign bus2.char_data = 8'h41 + 8'(bus2.char_addr);

    textlcd_refresh #(
        .INIT_DELAY(4), .CMD_WAIT(3), .CLEAR_WAIT(6),
        .E_PULSE(2), .NUM_LINES(2), .LINE_CHARS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    textlcd_refresh #(
        .INIT_DELAY(4), .CMD_WAIT(3), .CLEAR_WAIT(6),
        .E_PULSE(2), .NUM_LINES(1), .LINE_CHARS(4)
    ) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    // Bus monitors: record {rs,data} at each E rise, E-high widths,
    // E-rise cycle stamps and done pulses
    logic [8:0] byte_q [$];
    int         stamp_q [$];
    int         hi_q [$];
    int         done_cnt = 0;
    int         cyc      = 0;
    int         hi_cnt   = 0;
    logic       prev_e   = 1'b0;
    logic [8:0] byte2_q [$];
    int         done2_cnt = 0;
    int         max_addr2 = 0;
    logic       prev_e2   = 1'b0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        prev_e <= bus.lcd_e;
        hi_cnt <= bus.lcd_e ? hi_cnt + 1 : 0;
        if (bus.lcd_e && !prev_e) begin
            byte_q.push_back({bus.lcd_rs, bus.lcd_data});
            stamp_q.push_back(cyc);
        end
        if (!bus.lcd_e && prev_e) hi_q.push_back(hi_cnt);
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin
        prev_e2 <= bus2.lcd_e;
        if (bus2.lcd_e && !prev_e2) byte2_q.push_back({bus2.lcd_rs, bus2.lcd_data});
        if (bus2.done) done2_cnt <= done2_cnt + 1;
        if (!rst2 && (int'(bus2.char_addr) > max_addr2)) max_addr2 <= int'(bus2.char_addr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_done(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_refresh;
        @(negedge clk);
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
    endtask

    // Release reset at a negedge; count rising edges until 0x38 is on the bus
    task automatic release_and_time(input string tag);
        int n;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((bus.lcd_data !== 8'h38) && (n < 50));
        n_checks++;
        if (n !== 5) $display("FAIL %s_first_cmd_edges: got %0d expected 5", tag, n);
        else n_pass++;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 7;
        if (bus.lcd_e !== 1'b0) $display("FAIL reset_lcd_e: got %b expected 0", bus.lcd_e); else n_pass++;
        if (bus.lcd_rs !== 1'b0) $display("FAIL reset_lcd_rs: got %b expected 0", bus.lcd_rs); else n_pass++;
        if (bus.lcd_rw !== 1'b0) $display("FAIL reset_lcd_rw: got %b expected 0", bus.lcd_rw); else n_pass++;
        if (bus.lcd_data !== 8'h00) $display("FAIL reset_lcd_data: got %h expected 00", bus.lcd_data); else n_pass++;
        if (bus.char_addr !== 3'd0) $display("FAIL reset_char_addr: got %0d expected 0", bus.char_addr); else n_pass++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else n_pass++;
        if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", bus.busy); else n_pass++;
    endtask

    // Init stream plus first automatic redraw, with per-byte timing
    task automatic test_init_stream;
        logic [8:0] exp [15];
        int b, sb, hb, d0, dt;
        bit ok;
        exp = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080,
                9'h141, 9'h142, 9'h143, 9'h144, 9'h0C0,
                9'h145, 9'h146, 9'h147, 9'h148, 9'h000};
        b = byte_q.size(); sb = stamp_q.size(); hb = hi_q.size(); d0 = done_cnt;
        release_and_time("init");
        wait_done(d0 + 1, 400, ok);
        n_checks++;
        if (!ok) $display("FAIL init_done_timeout: got no done expected done"); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks += 3;
        if (bus.busy !== 1'b0) $display("FAIL init_busy_idle: got %b expected 0", bus.busy); else n_pass++;
        if (done_cnt - d0 !== 1) $display("FAIL init_done_count: got %0d expected 1", done_cnt - d0); else n_pass++;
        if (byte_q.size() - b !== 14) $display("FAIL init_byte_count: got %0d expected 14", byte_q.size() - b); else n_pass++;
        for (int k = 0; k < 14; k++) begin
            n_checks++;
            if (byte_q[b+k] !== exp[k]) $display("FAIL init_byte[%0d]: got %h expected %h", k, byte_q[b+k], exp[k]);
            else n_pass++;
        end
        for (int k = 0; k < 14; k++) begin
            n_checks++;
            if (hi_q[hb+k] !== 2) $display("FAIL init_e_width[%0d]: got %0d expected 2", k, hi_q[hb+k]);
            else n_pass++;
        end
        for (int k = 0; k < 13; k++) begin
            dt = stamp_q[sb+k+1] - stamp_q[sb+k];
            n_checks++;
            if (dt !== ((k == 2) ? 9 : 6))
                $display("FAIL init_spacing[%0d]: got %0d expected %0d", k, dt, (k == 2) ? 9 : 6);
            else n_pass++;
        end
    endtask

    task automatic test_refresh_idle;
        logic [8:0] exp [10];
        int b, d0;
        bit ok;
        exp = '{9'h080, 9'h141, 9'h142, 9'h143, 9'h144,
                9'h0C0, 9'h145, 9'h146, 9'h147, 9'h148};
        b = byte_q.size(); d0 = done_cnt;
        pulse_refresh();
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL idle_refresh_busy: got %b expected 1", bus.busy); else n_pass++;
        wait_done(d0 + 1, 400, ok);
        n_checks++;
        if (!ok) $display("FAIL idle_refresh_timeout: got no done expected done"); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks += 4;
        if (done_cnt - d0 !== 1) $display("FAIL idle_refresh_done_count: got %0d expected 1", done_cnt - d0); else n_pass++;
        if (byte_q.size() - b !== 10) $display("FAIL idle_refresh_byte_count: got %0d expected 10", byte_q.size() - b); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL idle_refresh_busy_end: got %b expected 0", bus.busy); else n_pass++;
        if (bus.char_addr !== 3'd0) $display("FAIL idle_refresh_addr_end: got %0d expected 0", bus.char_addr); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (byte_q[b+k] !== exp[k]) $display("FAIL idle_refresh_byte[%0d]: got %h expected %h", k, byte_q[b+k], exp[k]);
            else n_pass++;
        end
    endtask

    // Three requests during one redraw collapse into a single extra redraw
    task automatic test_back_to_back;
        int b, d0;
        bit ok;
        b = byte_q.size(); d0 = done_cnt;
        pulse_refresh();
        for (int r = 0; r < 3; r++) begin
            repeat (12) @(negedge clk);
            bus.refresh = 1'b1;
            @(negedge clk);
            bus.refresh = 1'b0;
        end
        wait_done(d0 + 2, 400, ok);
        n_checks++;
        if (!ok) $display("FAIL pending_timeout: got done %0d expected 2", done_cnt - d0); else n_pass++;
        repeat (150) @(negedge clk);
        n_checks += 5;
        if (done_cnt - d0 !== 2) $display("FAIL pending_done_count: got %0d expected 2", done_cnt - d0); else n_pass++;
        if (byte_q.size() - b !== 20) $display("FAIL pending_byte_count: got %0d expected 20", byte_q.size() - b); else n_pass++;
        if (byte_q[b+10] !== 9'h080) $display("FAIL pending_second_start: got %h expected 080", byte_q[b+10]); else n_pass++;
        if (byte_q[b+19] !== 9'h148) $display("FAIL pending_second_last: got %h expected 148", byte_q[b+19]); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL pending_busy_end: got %b expected 0", bus.busy); else n_pass++;
    endtask

    // A request in the done cycle still produces exactly one more redraw
    task automatic test_refresh_on_done;
        int b, d0, n;
        b = byte_q.size(); d0 = done_cnt;
        pulse_refresh();
        n = 0;
        while ((bus.done !== 1'b1) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.done !== 1'b1) $display("FAIL on_done_wait: got done %b expected 1", bus.done); else n_pass++;
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        repeat (150) @(negedge clk);
        n_checks += 2;
        if (done_cnt - d0 !== 2) $display("FAIL on_done_done_count: got %0d expected 2", done_cnt - d0); else n_pass++;
        if (byte_q.size() - b !== 20) $display("FAIL on_done_byte_count: got %0d expected 20", byte_q.size() - b); else n_pass++;
    endtask

    // Reset during the strobe of the second data byte
    task automatic test_reset_mid;
        int b, d0, n;
        bit ok;
        pulse_refresh();
        n = 0;
        while (!((bus.lcd_e === 1'b1) && (bus.lcd_rs === 1'b1) && (bus.lcd_data === 8'h42)) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.lcd_e !== 1'b1) $display("FAIL mid_strobe_reach: got lcd_e %b expected 1", bus.lcd_e); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks += 3;
        if (bus.lcd_e !== 1'b0) $display("FAIL mid_reset_async_e: got %b expected 0", bus.lcd_e); else n_pass++;
        if (bus.lcd_data !== 8'h00) $display("FAIL mid_reset_data: got %h expected 00", bus.lcd_data); else n_pass++;
        if (bus.busy !== 1'b1) $display("FAIL mid_reset_busy: got %b expected 1", bus.busy); else n_pass++;
        repeat (2) @(negedge clk);
        b = byte_q.size(); d0 = done_cnt;
        release_and_time("mid");
        wait_done(d0 + 1, 400, ok);
        n_checks += 3;
        if (!ok) $display("FAIL mid_done_timeout: got no done expected done"); else n_pass++;
        if (byte_q[b] !== 9'h038) $display("FAIL mid_restart_first: got %h expected 038", byte_q[b]); else n_pass++;
        if (byte_q.size() - b !== 14) $display("FAIL mid_restart_count: got %0d expected 14", byte_q.size() - b); else n_pass++;
    endtask

    task automatic test_one_line;
        logic [8:0] exp [9];
        int b, d0, n, n_c0;
        exp = '{9'h030, 9'h00C, 9'h001, 9'h006, 9'h080,
                9'h141, 9'h142, 9'h143, 9'h144};
        b = byte2_q.size(); d0 = done2_cnt;
        @(negedge clk);
        rst2 = 1'b0;
        n = 0;
        while ((done2_cnt < d0 + 1) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        n_c0 = 0;
        for (int k = b; k < byte2_q.size(); k++) if (byte2_q[k] === 9'h0C0) n_c0++;
        n_checks += 5;
        if (done2_cnt - d0 !== 1) $display("FAIL one_line_done_count: got %0d expected 1", done2_cnt - d0); else n_pass++;
        if (byte2_q.size() - b !== 9) $display("FAIL one_line_byte_count: got %0d expected 9", byte2_q.size() - b); else n_pass++;
        if (n_c0 !== 0) $display("FAIL one_line_no_c0: got %0d expected 0", n_c0); else n_pass++;
        if (max_addr2 !== 3) $display("FAIL one_line_max_addr: got %0d expected 3", max_addr2); else n_pass++;
        if (bus2.busy !== 1'b0) $display("FAIL one_line_busy_end: got %b expected 0", bus2.busy); else n_pass++;
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (byte2_q[b+k] !== exp[k]) $display("FAIL one_line_byte[%0d]: got %h expected %h", k, byte2_q[b+k], exp[k]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.refresh  = 1'b0;
        bus2.refresh = 1'b0;
        test_reset();
        test_init_stream();
        test_refresh_idle();
        test_back_to_back();
        test_refresh_on_done();
        test_reset_mid();
        test_one_line();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/textlcd_refresh.md
TEXTLCD_REFRESH -- requirements
Module: textlcd_refresh

Interface
REQ-001 The module SHALL expose the following parameters, one per line as name, default, meaning:
- INIT_DELAY, 70, power-up wait in clk cycles before the first command.
- CMD_WAIT, 30, post-E wait in cycles after every byte except Clear.
- CLEAR_WAIT, 100, post-E wait in cycles after Clear Display.
- E_PULSE, 2, lcd_e high time in cycles; legal range 1 or more.
- NUM_LINES, 2, display lines; legal values 1 or 2.
- LINE_CHARS, 16, characters per line; legal range 1..40.
REQ-002 The module SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- refresh  in  1  one-cycle redraw request.
- char_data  in  8  ASCII byte for the position on char_addr; combinational source.
- char_addr  out  clog2(NUM_LINES*LINE_CHARS), minimum 1  character index being fetched.
- busy  out  1  high while initialising or redrawing.
- done  out  1  one-cycle pulse at the end of each redraw.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  tied to 0 (write only).
- lcd_data  out  8  LCD bus.

Function
REQ-003 Every byte transfer SHALL take 1 + E_PULSE + W cycles, where W is CLEAR_WAIT for byte 0x01 and CMD_WAIT for all other bytes:
- Setup cycle: lcd_rs and lcd_data driven, lcd_e = 0.
- Strobe: E_PULSE cycles with lcd_e = 1.
- Wait: W cycles with lcd_e = 0.
REQ-004 lcd_rs and lcd_data SHALL hold constant from the setup cycle through the last wait cycle.
REQ-005 The state machine SHALL use states PWR_DLY, FUNC_SET, DISP_ON, CLEAR, ENTRY, LINE_ADDR, WR_CHAR, IDLE.
REQ-006 PWR_DLY SHALL count INIT_DELAY cycles and then enter FUNC_SET.
REQ-007 The init sequence SHALL send these commands with rs = 0, in this order:
- FUNC_SET: 0x38 if NUM_LINES = 2, otherwise 0x30.
- DISP_ON: 0x0C.
- CLEAR: 0x01.
- ENTRY: 0x06.
REQ-008 After ENTRY, the module SHALL start a redraw automatically, without any refresh request.
REQ-009 A redraw SHALL process each line L from 0 to NUM_LINES-1 as follows:
- LINE_ADDR sends command 0x80 | (L*0x40) with rs = 0.
- WR_CHAR then sends LINE_CHARS data bytes with rs = 1 for i = 0..LINE_CHARS-1.
REQ-010 char_addr SHALL equal L*LINE_CHARS+i at least one cycle before that byte's setup cycle.
REQ-011 char_data SHALL be registered into lcd_data on the setup-cycle edge.
REQ-012 On completion of the last character, done SHALL pulse for exactly one cycle and the state SHALL become IDLE in the same cycle.
REQ-013 busy SHALL be 1 in every state except IDLE; it falls in the same cycle that done pulses.
REQ-014 In IDLE, a refresh pulse SHALL start a redraw on the next cycle, beginning with LINE_ADDR for line 0. The init sequence is not repeated.
REQ-015 Refresh requests received while busy = 1 SHALL be held in a one-deep pending flag:
- Multiple requests during one busy period collapse into one.
- The pending redraw starts on the cycle after done, with IDLE lasting 0 cycles.
REQ-016 A refresh in the same cycle that done pulses SHALL count as pending.
REQ-017 lcd_rw SHALL be constant 0 at all times.
REQ-018 Character fetch SHALL have no wrap-around: char_addr never exceeds NUM_LINES*LINE_CHARS-1 and returns to 0 at the start of each redraw.

Reset
REQ-019 While rst = 1, the outputs SHALL be: lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 0x00, char_addr = 0, done = 0, busy = 1.
REQ-020 While rst = 1, all counters and the pending flag SHALL be 0 and the state SHALL be PWR_DLY.
REQ-021 Reset asserted mid-transfer SHALL drop lcd_e asynchronously. After release, the full init sequence restarts from PWR_DLY.

Structure
REQ-022 A shared package textlcd_pkg SHALL hold:
- the state enum;
- the command constants CMD_FUNC_8B2L, CMD_FUNC_8B1L, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY, CMD_DDRAM_L0 and CMD_DDRAM_L1.
REQ-023 The byte timing SHALL live in one sub-module, lcd_byte_xfer, which provides:
- inputs start, rs, data and long_wait;
- output ready, high when the sub-module can accept a new start;
- the setup/strobe/wait counter, parameterised by E_PULSE, CMD_WAIT and CLEAR_WAIT.

Verification
The bench uses INIT_DELAY=4, CMD_WAIT=3, CLEAR_WAIT=6, E_PULSE=2, NUM_LINES=2, LINE_CHARS=4, with char_data = 0x41 + char_addr.
REQ-024 Release reset -> the byte stream SHALL be:
- commands 0x38, 0x0C, 0x01, 0x06, 0x80, then data 0x41..0x44;
- command 0xC0, then data 0x45..0x48;
- then one done pulse and busy = 0.
REQ-025 Per-byte timing check -> each lcd_e high SHALL last exactly 2 cycles. The spacing from setup to the next setup SHALL be 6 cycles, or 9 cycles after 0x01.
REQ-026 Refresh pulsed in IDLE -> the stream SHALL be 0x80, 0x41..0x44, 0xC0, 0x45..0x48, with no init commands, then one done pulse.
REQ-027 Three refresh pulses during a redraw -> exactly one further redraw SHALL follow, with done pulsing twice in total.
REQ-028 rst asserted during the strobe of the second data byte -> lcd_e = 0 immediately; after release, 0x38 SHALL appear after 4 delay cycles.
REQ-029 Run with NUM_LINES=1 -> the function set byte SHALL be 0x30, no 0xC0 SHALL be sent, and char_addr SHALL stay within 0..3.
